am_lock_bip_check: RTL and testbench

//  RX-side per-lane 40GBASE-R alignment-marker lock and BIP checker (IEEE 802.3 82.2.18).
//  - Consumes the 66b block stream of one physical lane after block lock.
//  - Finds the AM inserted by the TX alignment generator and identifies the PCS lane (0-3).
//  - Flags marker slots so the deskew/AM-removal stage can drop them.
//  - Checks BIP3 against a locally computed BIP and counts errors.

---
 rtl/pcs_pkg.sv | 42 ++++
 rtl/am_lock_bip_check.sv | 163 ++++++++++++++++
 tb/tb_am_lock_bip_check.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS definitions: alignment-marker lane constants, BIP step function
// and the alignment-lock state type.
package pcs_pkg;

  // Sync header carried by every alignment marker (control block).
  localparam logic [1:0] AM_SYNC = 2'b01;

  // Marker payload per PCS lane: bits [25:2] hold M0..M2, bits [57:34] hold M4..M6.
  localparam logic [23:0] AM_M012 [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};
  localparam logic [23:0] AM_M456 [4] = '{24'hB8896F, 24'h193B0F, 24'h649A3A, 24'hC2865D};

  typedef enum logic [1:0] {
    FIND_1ST = 2'd0,
    COUNT_1  = 2'd1,
    LOCKED   = 2'd2
  } am_state_t;

  // Fold one 66b block into a BIP accumulator. Bit i collects every eighth
  // payload bit starting at 2+i; the sync header bits land in BIP[3] and BIP[4].
  function automatic logic [7:0] bip_step(input logic [7:0] acc, input logic [65:0] blk);
    logic [7:0] r;
    r = acc;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        r[i] = r[i] ^ blk[2 + i + 8 * k];
      end
    end
    r[3] = r[3] ^ blk[0];
    r[4] = r[4] ^ blk[1];
    return r;
  endfunction

  // One-hot-ish lane match vector; BIP fields [33:26] and [65:58] are ignored.
  function automatic logic [3:0] am_match(input logic [65:0] blk);
    logic [3:0] m;
    for (int l = 0; l < 4; l++) begin
      m[l] = (blk[1:0] == AM_SYNC) && (blk[25:2] == AM_M012[l]) && (blk[57:34] == AM_M456[l]);
    end
    return m;
  endfunction

endpackage

// File: rtl/am_lock_bip_check.sv
// Per-lane 40GBASE-R alignment-marker lock, marker-slot flagging and BIP3 check.
// All outputs are registered and aligned to block_out (one cycle after block_in).
//
// Stream qualifier: block_in is meaningful only while block_valid=1. A cycle with
// block_valid=0 carries no block; it advances nothing (position, BIP, FSM) and
// produces block_out_vld=0 with am_slot and bip_error low. There is no back-pressure.
module am_lock_bip_check
  import pcs_pkg::*;
#(
  parameter int AM_PERIOD   = 16384,
  parameter int INVLD_LIMIT = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 block_lock,
  input  logic [65:0]          block_in,
  input  logic                 block_valid,
  output logic [65:0]          block_out,
  output logic                 block_out_vld,
  output logic                 am_slot,
  output logic                 am_lock,
  output logic [1:0]           lane_id,
  output logic                 bip_error,
  output logic [ERR_CNT_W-1:0] bip_err_cnt,
  output am_state_t            fsm_state
);

  localparam int POS_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
  localparam int INV_W = $clog2(INVLD_LIMIT + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(AM_PERIOD - 1);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVLD_LIMIT - 1);

  am_state_t            state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d, pos_next;
  logic [INV_W-1:0]     invld_q, invld_d;
  logic [7:0]           acc_q, acc_d;
  logic [1:0]           cand_q, cand_d, cand_sel;
  logic [3:0]           match;
  logic                 match_any, at_slot;
  logic                 lock_d, slot_d, err_d;
  logic [1:0]           lane_d;
  logic [ERR_CNT_W-1:0] cnt_d;

  assign fsm_state = state_q;

  // Marker decode and position bookkeeping for the current input block.
  always_comb begin
    match     = am_match(block_in);
    match_any = |match;
    cand_sel  = 2'd0;
    for (int l = 3; l >= 0; l--) begin
      if (match[l]) cand_sel = 2'(l);
    end
    at_slot  = (pos_q == '0);
    pos_next = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
  end

  // Next-state, counters, BIP accumulator and output values.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    invld_d = invld_q;
    acc_d   = acc_q;
    cand_d  = cand_q;
    lock_d  = am_lock;
    lane_d  = lane_id;
    slot_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = bip_err_cnt;
    if (!block_lock) begin
      // Losing block lock forgets alignment but keeps the error history.
      state_d = FIND_1ST;
      pos_d   = '0;
      invld_d = '0;
      acc_d   = '0;
      cand_d  = '0;
      lock_d  = 1'b0;
      lane_d  = '0;
    end else if (block_valid) begin
      case (state_q)
        FIND_1ST: begin
          if (match_any) begin
            cand_d  = cand_sel;
            pos_d   = POS_W'(1);
            acc_d   = bip_step(8'h00, block_in);
            state_d = COUNT_1;
          end
        end
        COUNT_1: begin
          pos_d = pos_next;
          acc_d = bip_step(acc_q, block_in);
          if (at_slot) begin
            if (match[cand_q]) begin
              lock_d  = 1'b1;
              lane_d  = cand_q;
              invld_d = '0;
              acc_d   = bip_step(8'h00, block_in);
              state_d = LOCKED;
            end else begin
              // The mismatching block is dropped, not retried as a first marker.
              state_d = FIND_1ST;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_next;
          acc_d = bip_step(acc_q, block_in);
          if (at_slot) begin
            slot_d = 1'b1;
            acc_d  = bip_step(8'h00, block_in);
            if (match[lane_id]) begin
              invld_d = '0;
              if (block_in[33:26] != acc_q) begin
                err_d = 1'b1;
                if (bip_err_cnt != '1) cnt_d = bip_err_cnt + ERR_CNT_W'(1);
              end
            end else if (invld_q == INV_LAST) begin
              invld_d = '0;
              lock_d  = 1'b0;
              state_d = FIND_1ST;
            end else begin
              invld_d = invld_q + INV_W'(1);
            end
          end
        end
        default: state_d = FIND_1ST;
      endcase
    end
  end

  // State and output registers; reset clears everything including the error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FIND_1ST;
      pos_q         <= '0;
      invld_q       <= '0;
      acc_q         <= '0;
      cand_q        <= '0;
      block_out     <= '0;
      block_out_vld <= 1'b0;
      am_slot       <= 1'b0;
      am_lock       <= 1'b0;
      lane_id       <= '0;
      bip_error     <= 1'b0;
      bip_err_cnt   <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      invld_q       <= invld_d;
      acc_q         <= acc_d;
      cand_q        <= cand_d;
      block_out     <= block_lock ? block_in : '0;
      block_out_vld <= block_lock & block_valid;
      am_slot       <= slot_d;
      am_lock       <= lock_d;
      lane_id       <= lane_d;
      bip_error     <= err_d;
      bip_err_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_am_lock_bip_check.sv
// Bench for am_lock_bip_check with AM_PERIOD=16: table of single-block marker
// vectors, then directed period sequences with random data, all scored per
// cycle against a bit-level reference model.
module tb_am_lock_bip_check;
  import pcs_pkg::*;

  localparam int PERIOD = 16;
  localparam int INVLD  = 4;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [23:0] TB_M012 [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};
  localparam logic [23:0] TB_M456 [4] = '{24'hB8896F, 24'h193B0F, 24'h649A3A, 24'hC2865D};

  logic             clk = 1'b0;
  logic             reset_n, block_lock, block_valid;
  logic [65:0]      block_in;
  logic [65:0]      block_out;
  logic             block_out_vld, am_slot, am_lock, bip_error;
  logic [1:0]       lane_id;
  logic [CNT_W-1:0] bip_err_cnt;
  am_state_t        fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int               m_mode, m_n, m_anchor, m_cand, m_miss;
  logic [7:0]       m_bip;
  logic [65:0]      e_out;
  logic             e_vld, e_slot, e_lock, e_err;
  logic [1:0]       e_lane;
  logic [CNT_W-1:0] e_cnt;

  // Generator state
  logic [7:0] g_bip;
  int         inv_pct;

  typedef struct {
    logic [65:0] blk;
    logic        exp_leave;
  } vec_t;
  vec_t vecs [8];

  am_lock_bip_check #(.AM_PERIOD(PERIOD), .INVLD_LIMIT(INVLD), .ERR_CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .block_lock(block_lock), .block_in(block_in),
    .block_valid(block_valid), .block_out(block_out), .block_out_vld(block_out_vld),
    .am_slot(am_slot), .am_lock(am_lock), .lane_id(lane_id), .bip_error(bip_error),
    .bip_err_cnt(bip_err_cnt), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // BIP by bit membership: every payload bit j>=2 belongs to lane (j-2) mod 8,
  // sync bits 0 and 1 belong to BIP[3] and BIP[4].
  function automatic logic [7:0] bip_add(input logic [7:0] a, input logic [65:0] b);
    logic [7:0] r;
    int idx;
    r = a;
    for (int j = 0; j < 66; j++) begin
      if (b[j]) begin
        idx = (j < 2) ? 3 + j : (j - 2) % 8;
        r[idx] = ~r[idx];
      end
    end
    return r;
  endfunction

  function automatic int ref_lane(input logic [65:0] b);
    for (int l = 0; l < 4; l++) begin
      if (b[1:0] == 2'b01 && b[25:2] == TB_M012[l] && b[57:34] == TB_M456[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [65:0] mk_marker(input int lane, input logic [7:0] bip);
    logic [65:0] b;
    b = '0;
    b[1:0]   = 2'b01;
    b[25:2]  = TB_M012[lane];
    b[33:26] = bip;
    b[57:34] = TB_M456[lane];
    b[65:58] = ~bip;
    return b;
  endfunction

  function automatic logic [65:0] rnd_data();
    logic [65:0] d;
    d[31:0]  = $urandom;
    d[63:32] = $urandom;
    d[65:64] = 2'($urandom_range(0, 3));
    d[1:0]   = 2'b10;
    return d;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_anchor = 0; m_cand = 0; m_miss = 0; m_bip = '0;
    e_out = '0; e_vld = 0; e_slot = 0; e_lock = 0; e_err = 0; e_lane = '0; e_cnt = '0;
  endtask

  // Expected outputs after one clock with the given inputs.
  task automatic model(input logic [65:0] b, input logic v, input logic bl);
    int ln, rel;
    e_slot = 0;
    e_err  = 0;
    if (!bl) begin
      m_mode = 0; m_miss = 0; m_bip = '0;
      e_lock = 0; e_lane = '0; e_out = '0; e_vld = 0;
      return;
    end
    e_out = b;
    e_vld = v;
    if (!v) return;
    ln  = ref_lane(b);
    rel = (m_n - m_anchor) % PERIOD;
    case (m_mode)
      0: if (ln >= 0) begin
        m_cand = ln; m_anchor = m_n; m_bip = bip_add(8'h00, b); m_mode = 1;
      end
      1: if (rel != 0) m_bip = bip_add(m_bip, b);
         else if (ln == m_cand) begin
           e_lock = 1; e_lane = 2'(m_cand); m_mode = 2; m_miss = 0; m_bip = bip_add(8'h00, b);
         end else m_mode = 0;
      default: if (rel != 0) m_bip = bip_add(m_bip, b);
        else begin
          e_slot = 1;
          if (ln == int'(e_lane)) begin
            m_miss = 0;
            if (b[33:26] != m_bip) begin
              e_err = 1;
              if (e_cnt != CNT_MAX) e_cnt = e_cnt + 1'b1;
            end
          end else begin
            m_miss++;
            if (m_miss == INVLD) begin
              e_lock = 0; m_mode = 0; m_miss = 0;
            end
          end
          m_bip = bip_add(8'h00, b);
        end
    endcase
    m_n++;
  endtask

  task automatic compare_all();
    chk("block_out", block_out, e_out);
    chk("block_out_vld", 66'(block_out_vld), 66'(e_vld));
    chk("am_slot", 66'(am_slot), 66'(e_slot));
    chk("am_lock", 66'(am_lock), 66'(e_lock));
    chk("lane_id", 66'(lane_id), 66'(e_lane));
    chk("bip_error", 66'(bip_error), 66'(e_err));
    chk("bip_err_cnt", 66'(bip_err_cnt), 66'(e_cnt));
    chk("fsm_in_find", 66'(fsm_state == FIND_1ST), 66'(m_mode == 0));
  endtask

  // Driver: apply one cycle of inputs, then score outputs 1 time unit after the edge.
  task automatic step(input logic [65:0] blk, input logic vld, input logic bl);
    block_in = blk; block_valid = vld; block_lock = bl;
    model(blk, vld, bl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_blk(input logic [65:0] b);
    while ($urandom_range(0, 99) < inv_pct) step(rnd_data(), 1'b0, 1'b1);
    step(b, 1'b1, 1'b1);
  endtask

  // kind: 0 marker with correct BIP, 1 marker with inverted BIP, 2 data in the slot
  task automatic send_slot(input int lane, input int kind);
    logic [65:0] b;
    if (kind == 2) b = rnd_data();
    else b = mk_marker(lane, (kind == 1) ? ~g_bip : g_bip);
    g_bip = bip_add(8'h00, b);
    send_blk(b);
  endtask

  task automatic send_data(input int n, input bit corrupt);
    logic [65:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd_data();
      g_bip = bip_add(g_bip, d);
      if (corrupt && i == n / 2) d[20] = ~d[20];
      send_blk(d);
    end
  endtask

  task automatic send_period(input int lane, input int kind);
    send_slot(lane, kind);
    send_data(PERIOD - 1, 1'b0);
  endtask

  initial begin
    logic [65:0] t;
    // Clock/reset
    reset_n = 0; block_lock = 0; block_valid = 0; block_in = '0;
    g_bip = '0; inv_pct = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1;

    // Single-block marker recognition table
    vecs[0] = '{mk_marker(0, 8'h00), 1'b1};
    vecs[1] = '{mk_marker(1, 8'h5A), 1'b1};
    vecs[2] = '{mk_marker(2, 8'hFF), 1'b1};
    vecs[3] = '{mk_marker(3, 8'h3C), 1'b1};
    t = mk_marker(0, 8'h11); t[57:34] = TB_M456[1];   vecs[4] = '{t, 1'b0};
    t = mk_marker(2, 8'h22); t[1:0] = 2'b10;          vecs[5] = '{t, 1'b0};
    t = mk_marker(3, 8'h33); t[40] = ~t[40];          vecs[6] = '{t, 1'b0};
    t = mk_marker(1, 8'h44); t[30] = ~t[30]; t[62] = ~t[62]; vecs[7] = '{t, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].blk, 1'b1, 1'b1);
      chk("tbl_leave_find", 66'(fsm_state != FIND_1ST), 66'(vecs[i].exp_leave));
      step(rnd_data(), 1'b1, 1'b0);
    end

    // 1: lane-2 markers, lock on the second
    send_period(2, 0);
    chk("t1_no_lock_first", 66'(am_lock), 66'(0));
    send_slot(2, 0);
    chk("t1_lock_second", 66'(am_lock), 66'(1));
    chk("t1_lane", 66'(lane_id), 66'(2));
    send_data(PERIOD - 1, 1'b0);
    send_slot(2, 0);
    chk("t1_slot", 66'(am_slot), 66'(1));
    send_data(PERIOD - 1, 1'b0);
    send_period(2, 0);
    send_period(2, 0);
    chk("t1_no_errors", 66'(bip_err_cnt), 66'(0));

    // 2: one corrupted data bit
    send_slot(2, 0);
    send_data(PERIOD - 1, 1'b1);
    send_slot(2, 0);
    chk("t2_bip_error", 66'(bip_error), 66'(1));
    chk("t2_cnt", 66'(bip_err_cnt), 66'(1));
    send_data(PERIOD - 1, 1'b0);
    send_slot(2, 0);
    chk("t2_no_repeat", 66'(bip_error), 66'(0));
    chk("t2_lock_kept", 66'(am_lock), 66'(1));
    send_data(PERIOD - 1, 1'b0);

    // 3: four missing markers drop lock; three bad then good keeps it
    for (int k = 0; k < 4; k++) begin
      send_slot(2, 2);
      if (k == 2) chk("t3_lock_after_3", 66'(am_lock), 66'(1));
      if (k == 3) begin
        chk("t3_lock_lost", 66'(am_lock), 66'(0));
        chk("t3_lane_held", 66'(lane_id), 66'(2));
      end
      send_data(PERIOD - 1, 1'b0);
    end
    send_period(2, 0);
    send_slot(2, 0);
    chk("t3_relock", 66'(am_lock), 66'(1));
    send_data(PERIOD - 1, 1'b0);
    send_period(2, 2);
    send_period(1, 0);
    send_period(2, 2);
    send_slot(2, 0);
    chk("t3_lock_3bad_1good", 66'(am_lock), 66'(1));
    send_data(PERIOD - 1, 1'b0);
    send_period(2, 2);
    send_period(2, 2);
    send_period(2, 2);
    chk("t3_invld_cleared", 66'(am_lock), 66'(1));
    send_period(2, 0);

    // 4: lane 0 then lane 1 gives no lock
    step(rnd_data(), 1'b1, 1'b0);
    send_period(0, 0);
    send_slot(1, 0);
    chk("t4_back_to_find", 66'(fsm_state == FIND_1ST), 66'(1));
    chk("t4_no_lock", 66'(am_lock), 66'(0));
    send_data(PERIOD - 1, 1'b0);
    send_period(1, 0);
    send_slot(1, 0);
    chk("t4_lane1_lock", 66'(lane_id), 66'(1));
    send_data(PERIOD - 1, 1'b0);

    // 5: random 30% invalid cycles
    step(rnd_data(), 1'b1, 1'b0);
    inv_pct = 30;
    send_period(2, 0);
    send_period(2, 0);
    send_period(2, 0);
    send_slot(2, 0);
    chk("t5_lock", 66'(am_lock), 66'(1));
    chk("t5_lane", 66'(lane_id), 66'(2));
    chk("t5_cnt", 66'(bip_err_cnt), 66'(1));
    send_data(PERIOD - 1, 1'b0);
    inv_pct = 0;

    // Counter saturation
    for (int k = 0; k < 16; k++) send_period(2, 1);
    chk("sat_cnt", 66'(bip_err_cnt), 66'(CNT_MAX));
    chk("sat_lock", 66'(am_lock), 66'(1));

    // 6: block_lock loss then reset, both mid-period
    send_slot(2, 0);
    send_data(5, 1'b0);
    step(rnd_data(), 1'b1, 1'b0);
    chk("t6_bl_unlock", 66'(am_lock), 66'(0));
    chk("t6_cnt_survives", 66'(bip_err_cnt), 66'(CNT_MAX));
    step(rnd_data(), 1'b1, 1'b0);
    step(rnd_data(), 1'b1, 1'b0);
    send_data(PERIOD - 6, 1'b0);
    send_period(2, 0);
    send_slot(2, 0);
    chk("t6_relock_bl", 66'(am_lock), 66'(1));
    send_data(6, 1'b0);
    reset_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("t6_rst_cnt", 66'(bip_err_cnt), 66'(0));
    @(negedge clk);
    reset_n = 1;
    send_data(PERIOD - 7, 1'b0);
    send_period(2, 0);
    send_slot(2, 0);
    chk("t6_relock_rst", 66'(am_lock), 66'(1));
    send_data(PERIOD - 1, 1'b0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
